// File: rtl/ib_pkg.sv
// Shared types and constants for the fetch-to-dispatch instruction buffer.
package ib_pkg;

  localparam int unsigned IB_DEPTH = 8;
  localparam int unsigned IB_PTR_W = $clog2(IB_DEPTH);

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } ib_entry_t;

endpackage

// File: rtl/inst_buffer.sv
// inst_buffer: 2-way circular instruction FIFO between fetch and dispatch.
// Accepts 0-2 instructions per cycle (all-or-nothing), retires 0-2 per cycle,
// flushes completely on br_pred_wrong.
// Optional feature macro: IB_DEQ_CREDIT_EN -- when defined, same-cycle dequeue
// counts as free space for enqueue admission (ib_stall is unaffected).
module inst_buffer
  import ib_pkg::*;
#(
  parameter int unsigned DEPTH = IB_DEPTH
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [1:0]              if_nFetched,
  input  logic [31:0]             if_inst0,
  input  logic [31:0]             if_inst1,
  input  logic [63:0]             if_pc0,
  input  logic [63:0]             if_pc1,
  input  logic [1:0]              haz_nDispatched,
  input  logic                    br_pred_wrong,
  output logic [1:0]              ib_nIsnBuffer,
  output logic [31:0]             ib_inst0,
  output logic [31:0]             ib_inst1,
  output logic [63:0]             ib_pc0,
  output logic [63:0]             ib_pc1,
  output logic                    ib_stall,
  output logic [$clog2(DEPTH):0]  ib_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  // Free-space arithmetic is two bits wider than the pointers so that
  // DEPTH + 2 (full buffer plus dequeue credit) cannot overflow.
  localparam int unsigned FW = PW + 2;
  localparam logic [FW-1:0] DEPTH_F = FW'(DEPTH);

  logic [PW-1:0]  head;
  logic [PW-1:0]  tail;
  logic [PW-1:0]  head_p1;
  logic [PW-1:0]  tail_p1;
  logic [CW-1:0]  count;
  ib_entry_t      entries [DEPTH];

  logic [1:0]     avail;
  logic [1:0]     deq_n;
  logic [1:0]     fetch_n;
  logic [1:0]     enq_n;
  logic [FW-1:0]  free_n;

  // Dequeue clamp and all-or-nothing enqueue admission.
  always_comb begin
    avail   = (count >= CW'(2)) ? 2'd2 : count[1:0];
    deq_n   = (haz_nDispatched < avail) ? haz_nDispatched : avail;
    fetch_n = (if_nFetched == 2'd3) ? 2'd2 : if_nFetched;
`ifdef IB_DEQ_CREDIT_EN
    free_n  = DEPTH_F - FW'(count) + FW'(deq_n);
`else
    free_n  = DEPTH_F - FW'(count);
`endif
    enq_n   = (FW'(fetch_n) <= free_n) ? fetch_n : 2'd0;
  end

  // Pointer and occupancy registers; reset and flush both empty the buffer.
  always_ff @(posedge clock) begin
    if (reset || br_pred_wrong) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(deq_n);
      tail  <= tail + PW'(enq_n);
      count <= count - CW'(deq_n) + CW'(enq_n);
    end
  end

  // Entry storage write; contents are never reset.
  always_ff @(posedge clock) begin
    if (!reset && !br_pred_wrong) begin
      if (enq_n != 2'd0) entries[tail]    <= '{pc: if_pc0, inst: if_inst0};
      if (enq_n == 2'd2) entries[tail_p1] <= '{pc: if_pc1, inst: if_inst1};
    end
  end

  // Head-side reads and status outputs derived from registered state only.
  always_comb begin
    head_p1       = head + PW'(1);
    tail_p1       = tail + PW'(1);
    ib_inst0      = entries[head].inst;
    ib_pc0        = entries[head].pc;
    ib_inst1      = entries[head_p1].inst;
    ib_pc1        = entries[head_p1].pc;
    ib_nIsnBuffer = avail;
    ib_stall      = (count > CW'(DEPTH - 2));
    ib_count      = count;
  end

endmodule

// File: tb/tb_inst_buffer.sv
// Self-checking bench for inst_buffer: directed steps plus a random phase,
// checked against a reference queue of expected entries.
module tb_inst_buffer;
  import ib_pkg::*;

  localparam int unsigned DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  if_nFetched = '0;
  logic [31:0] if_inst0 = '0;
  logic [31:0] if_inst1 = '0;
  logic [63:0] if_pc0 = '0;
  logic [63:0] if_pc1 = '0;
  logic [1:0]  haz_nDispatched = '0;
  logic        br_pred_wrong = 1'b0;
  logic [1:0]  ib_nIsnBuffer;
  logic [31:0] ib_inst0;
  logic [31:0] ib_inst1;
  logic [63:0] ib_pc0;
  logic [63:0] ib_pc1;
  logic        ib_stall;
  logic [3:0]  ib_count;

  inst_buffer #(.DEPTH(DEPTH)) dut (
    .clock(clock),
    .reset(reset),
    .if_nFetched(if_nFetched),
    .if_inst0(if_inst0),
    .if_inst1(if_inst1),
    .if_pc0(if_pc0),
    .if_pc1(if_pc1),
    .haz_nDispatched(haz_nDispatched),
    .br_pred_wrong(br_pred_wrong),
    .ib_nIsnBuffer(ib_nIsnBuffer),
    .ib_inst0(ib_inst0),
    .ib_inst1(ib_inst1),
    .ib_pc0(ib_pc0),
    .ib_pc1(ib_pc1),
    .ib_stall(ib_stall),
    .ib_count(ib_count)
  );

  always #5 clock = ~clock;

  int          total = 0;
  int          bad = 0;
  ib_entry_t   mq[$];
  logic [63:0] next_pc = 64'h100;

  function automatic logic [31:0] inst_of(input logic [63:0] pc);
    return (pc[31:0] * 32'd3) ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    int n;
    n = mq.size();
    chk({tag, ":count"}, 64'(ib_count), 64'(n));
    chk({tag, ":nisn"}, 64'(ib_nIsnBuffer), 64'((n >= 2) ? 2 : n));
    chk({tag, ":stall"}, 64'(ib_stall), 64'(n >= int'(DEPTH) - 1));
    if (n >= 1) begin
      chk({tag, ":pc0"}, ib_pc0, mq[0].pc);
      chk({tag, ":inst0"}, 64'(ib_inst0), 64'(mq[0].inst));
    end
    if (n >= 2) begin
      chk({tag, ":pc1"}, ib_pc1, mq[1].pc);
      chk({tag, ":inst1"}, 64'(ib_inst1), 64'(mq[1].inst));
    end
  endtask

  // One clock cycle: drive inputs, pop/compare dispatched entries, push
  // admitted entries, then advance to the following falling edge.
  task automatic step(input int nf, input int nd, input bit fl, input bit rs);
    int n, avail, dq, fn, free, en;
    ib_entry_t e;
    n     = mq.size();
    avail = (n >= 2) ? 2 : n;
    dq    = (nd < avail) ? nd : avail;
    fn    = (nf > 2) ? 2 : nf;
    free  = int'(DEPTH) - n;
`ifdef IB_DEQ_CREDIT_EN
    free  = free + dq;
`endif
    en    = (fn <= free) ? fn : 0;

    if_nFetched     = 2'(nf);
    haz_nDispatched = 2'(nd);
    br_pred_wrong   = fl;
    reset           = rs;
    if_pc0          = next_pc;
    if_inst0        = inst_of(next_pc);
    if_pc1          = next_pc + 64'd4;
    if_inst1        = inst_of(next_pc + 64'd4);
    next_pc         = next_pc + 64'd8;

    if (!rs && !fl) begin
      for (int i = 0; i < dq; i++) begin
        e = mq.pop_front();
        chk("deq_pc", (i == 0) ? ib_pc0 : ib_pc1, e.pc);
      end
      if (en >= 1) mq.push_back('{pc: if_pc0, inst: if_inst0});
      if (en == 2) mq.push_back('{pc: if_pc1, inst: if_inst1});
    end

    @(posedge clock);
    if (rs || fl) mq.delete();
    @(negedge clock);
  endtask

  initial begin
    logic [63:0] p;
    int guard;

    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check_state("reset");

    // First pair becomes visible one cycle after enqueue.
    step(2, 0, 0, 0);
    check_state("t1");
    chk("t1_pc0", ib_pc0, 64'h100);
    chk("t1_pc1", ib_pc1, 64'h104);
    chk("t1_count", 64'(ib_count), 64'd2);

    // Five queued, single dispatch.
    step(2, 0, 0, 0);
    step(1, 0, 0, 0);
    check_state("t2_five");
    step(0, 1, 0, 0);
    check_state("t2");
    chk("t2_count", 64'(ib_count), 64'd4);
    chk("t2_pc0", ib_pc0, 64'h104);

    // Fill to DEPTH then fetch 2 while dispatching 2.
    step(2, 0, 0, 0);
    step(2, 0, 0, 0);
    check_state("t3_full");
    chk("t3_full_stall", 64'(ib_stall), 64'd1);
    step(2, 2, 0, 0);
    check_state("t3");
`ifdef IB_DEQ_CREDIT_EN
    chk("t3_count", 64'(ib_count), 64'd8);
`else
    chk("t3_count", 64'(ib_count), 64'd6);
`endif

    // Drain to one entry, then over-dispatch.
    guard = 0;
    while (mq.size() > 1 && guard < 20) begin
      step(0, (mq.size() >= 3) ? 3 : 1, 0, 0);
      guard++;
    end
    check_state("t4_one");
    chk("t4_one_count", 64'(ib_count), 64'd1);
    step(0, 2, 0, 0);
    check_state("t4");
    chk("t4_count", 64'(ib_count), 64'd0);
    chk("t4_nisn", 64'(ib_nIsnBuffer), 64'd0);

    // Flush with same-cycle fetch and dispatch, then refill.
    step(2, 0, 0, 0);
    step(2, 0, 0, 0);
    step(2, 0, 0, 0);
    check_state("t5_six");
    step(2, 1, 1, 0);
    check_state("t5");
    chk("t5_count", 64'(ib_count), 64'd0);
    chk("t5_stall", 64'(ib_stall), 64'd0);
    p = next_pc;
    step(2, 0, 0, 0);
    check_state("t5_refill");
    chk("t5_refill_pc0", ib_pc0, p);
    chk("t5_refill_pc1", ib_pc1, p + 64'd4);

    // Reset mid-operation overrides flush and enqueue.
    step(2, 0, 0, 0);
    step(2, 2, 1, 1);
    check_state("t6");
    chk("t6_count", 64'(ib_count), 64'd0);

    // Random traffic across pointer wrap.
    for (int i = 0; i < 200; i++) begin
      step(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           ($urandom_range(0, 31) == 0), 1'b0);
      check_state("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_buffer.md
# inst_buffer

2-way fetch-to-dispatch instruction buffer between the fetch stage and dispatch. It is a circular FIFO that accepts 0–2 fetched instructions per cycle. It reports how many are ready as `ib_nIsnBuffer`, capped at 2, to the dispatch hazard logic. It retires 0–2 entries per cycle according to the returned `haz_nDispatched`, and flushes completely on a branch mispredict.

## Interface
Parameters:
- `DEPTH`, 8: number of entries; power of two, ≥4.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `if_nFetched` in 2: instructions presented this cycle (0, 1, 2; 3 is treated as 2); slot 0 is older.
- `if_inst0`, `if_inst1` in 32 each: instruction words.
- `if_pc0`, `if_pc1` in 64 each: instruction PCs.
- `haz_nDispatched` in 2: entries consumed by dispatch this cycle.
- `br_pred_wrong` in 1: flush request.
- `ib_nIsnBuffer` out 2: min(count, 2).
- `ib_inst0`, `ib_inst1` out 32 each: head and head+1 instruction words.
- `ib_pc0`, `ib_pc1` out 64 each: head and head+1 PCs.
- `ib_stall` out 1: fewer than 2 free entries; fetch must hold.
- `ib_count` out log2(DEPTH)+1: current occupancy.

## Operation
- State: `head`, `tail` (log2(DEPTH) bits, wrap modulo DEPTH), `count` (0..DEPTH), entry array of {pc, inst}.
- **Dequeue:**
  - deq_n = min(haz_nDispatched, min(count, 2)).
  - `haz_nDispatched` greater than the available count is clamped, never underflows.
  - `head` advances by deq_n.
- **Enqueue** is all-or-nothing:
  - enq_n = min(if_nFetched, 2) if free ≥ that value, else 0.
  - free = DEPTH − count; with `IB_DEQ_CREDIT_EN`, free = DEPTH − count + deq_n.
  - Slot 0 is written at `tail`, slot 1 at `tail+1`, modulo DEPTH.
  - `tail` advances by enq_n.
- **Update:** count_next = count − deq_n + enq_n. Simultaneous enqueue and dequeue are legal, including when count = DEPTH (credit mode) or 0.
- **Empty:** count 0 means dequeue is ignored; enqueued data is not visible until the next cycle (no bypass).
- **Flush:** on `br_pred_wrong` = 1, next-cycle head = tail = count = 0. Same-cycle enqueue and dequeue are discarded. Flush has priority over everything except reset.
- **Read outputs:**
  - `ib_inst*`/`ib_pc*` read combinationally from `head`/`head+1`.
  - Contents are don't-care when the corresponding index ≥ count; the bench must not check them.
- **Stall:** `ib_stall` = (DEPTH − count) < 2, computed from registered count only, in both configurations.

## Timing
- All state updates on the rising edge of `clock`.
- **Reset:** head = tail = count = 0, so `ib_nIsnBuffer` = 0, `ib_count` = 0, `ib_stall` = 0. The entry array is not reset.
- `reset` mid-operation discards all contents in one cycle and overrides `br_pred_wrong` and enqueue.
- **Latency:** an instruction enqueued in cycle N is reported in `ib_nIsnBuffer` in cycle N+1, earliest dispatch N+1.
- `ib_nIsnBuffer`, `ib_stall`, `ib_count` are purely functions of registers, with no input-to-output combinational path.
- **Handshake:** dispatch consumes exactly the `haz_nDispatched` oldest entries in the cycle it is asserted; no acknowledge.

## Configuration
- `IB_DEQ_CREDIT_EN` defined: enqueue admission counts same-cycle dequeue as freed space. A full buffer (count = DEPTH) dequeuing 2 can accept 2 in the same cycle. `ib_stall` is unchanged, so credit only helps when fetch presents despite stall.
- Not defined: admission uses registered free space only; a full buffer rejects all enqueues regardless of dequeue.

## Structure
- Shared package `ib_pkg`:
  - `IB_DEPTH` default constant.
  - `ib_entry_t` packed struct {logic [63:0] pc; logic [31:0] inst}.
  - `IB_PTR_W` = $clog2(IB_DEPTH).
- Single module; no sub-module. Pointer wrap uses natural log2(DEPTH)-bit overflow.

## Test plan
- Reset, then if_nFetched=2 (PC 0x100, 0x104) → next cycle ib_nIsnBuffer=2, ib_pc0=0x100, ib_pc1=0x104, ib_count=2.
- 5 entries queued, haz_nDispatched=1 with if_nFetched=0 → next cycle ib_count=4, ib_pc0 = formerly second entry.
- Fill to DEPTH=8, then if_nFetched=2 with haz_nDispatched=2:
  - without credit → count=6 and both fetched entries dropped;
  - with `IB_DEQ_CREDIT_EN` → count=8, new PCs at tail.
- count=1, haz_nDispatched=2 → count=0, no underflow; ib_nIsnBuffer=0.
- 6 entries queued, br_pred_wrong=1 with if_nFetched=2 → next cycle count=0, ib_stall=0; refill succeeds at pointers 0/1.
- Wrap: 200 cycles of random enqueue/dequeue against a reference queue model → PC order preserved across head/tail wrap, ib_stall asserted exactly when count ≥ 7.
